hazard_scheduler: RTL and testbench

// - Pipeline hazard controller for the microcoded core; sequences bubble injection between decode and execute.
// - Arbitrates three stall sources: load-use (is_load), taken branch (is_branch_taken) and data-memory busy (mem_busy).
// - Drives is_void (bubble into execute), pc_hold (freeze fetch/decode) and flush (kill younger fetched words).
// - Keeps a saturating bubble-cycle count for performance monitoring.

---
 rtl/hazard_scheduler_pkg.sv | 39 +++
 rtl/hazard_scheduler_if.sv | 32 +++
 rtl/hazard_scheduler_void_counter.sv | 35 +++
 rtl/hazard_scheduler.sv | 102 ++++++++++
 tb/tb_hazard_scheduler.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/hazard_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : hazard_scheduler_pkg                                    |
// | Purpose  : State encodings and output decode for hazard_scheduler  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package hazard_scheduler_pkg;

    localparam int STATE_W = 2;
    localparam int CNT_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_VOID     = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_WAIT_MEM = 2'd3
    } state_t;

    typedef struct packed {
        logic is_void;
        logic pc_hold;
        logic flush;
    } hz_out_t;

    // Moore decode; FLUSH lets fetch advance to the branch target.
    function automatic hz_out_t decode_outputs(input state_t s);
        hz_out_t o;
        o = '0;
        case (s)
            ST_VOID:     begin o.is_void = 1'b1; o.pc_hold = 1'b1; end
            ST_FLUSH:    begin o.is_void = 1'b1; o.flush   = 1'b1; end
            ST_WAIT_MEM: begin o.is_void = 1'b1; o.pc_hold = 1'b1; end
            default:     o = '0;
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : hazard_scheduler_if                                     |
// | Purpose  : Stall requests in, bubble/hold/flush controls out       |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface hazard_scheduler_if #(
    parameter int STAT_W = 16
);
    import hazard_scheduler_pkg::*;

    logic               is_load;
    logic               is_branch_taken;
    logic               mem_busy;
    logic               is_void;
    logic               pc_hold;
    logic               flush;
    logic [STATE_W-1:0] state_dbg;
    logic [STAT_W-1:0]  void_count;

    modport master (
        output is_load, is_branch_taken, mem_busy,
        input  is_void, pc_hold, flush, state_dbg, void_count
    );

    modport slave (
        input  is_load, is_branch_taken, mem_busy,
        output is_void, pc_hold, flush, state_dbg, void_count
    );

endinterface
`default_nettype wire

// File: rtl/hazard_scheduler_void_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : hazard_scheduler_void_counter                           |
// | Purpose  : Loadable 3-bit down-counter that parks at 1             |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module hazard_scheduler_void_counter
    import hazard_scheduler_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] load_val,
    output logic      [CNT_W-1:0] cnt,
    output logic                  last
);

    logic [CNT_W-1:0] r_cnt;

    // Never wraps: a loaded value counts down to 1 and holds there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt > CNT_W'(1)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/hazard_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : hazard_scheduler                                        |
// | Purpose  : Load-use / branch / memory-busy bubble sequencer        |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int LOAD_VOID_CYCLES    = 2,
    parameter int BRANCH_FLUSH_CYCLES = 1,
    parameter int STAT_W              = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    hazard_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0]  c_load_val  = CNT_W'(LOAD_VOID_CYCLES);
    localparam logic [CNT_W-1:0]  c_flush_val = CNT_W'(BRANCH_FLUSH_CYCLES);
    localparam bit                c_load_en   = (LOAD_VOID_CYCLES > 0);
    localparam logic [STAT_W-1:0] c_stat_max  = '1;

    state_t             r_state;
    hz_out_t            r_out;
    logic [STAT_W-1:0]  r_void_count;

    state_t             w_state_nxt;
    logic               w_cnt_load;
    logic [CNT_W-1:0]   w_cnt_val;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_cnt_last;
    logic               w_cnt_done;

    hazard_scheduler_void_counter u_void_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_cnt_load),
        .load_val (w_cnt_val),
        .cnt      (w_cnt),
        .last     (w_cnt_last)
    );

    // An unloaded (zero) counter also ends a timed state so it can never stick.
    assign w_cnt_done = w_cnt_last || (w_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_val   = c_flush_val;
        if (bus.is_branch_taken) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_load  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.mem_busy) begin
                        w_state_nxt = ST_WAIT_MEM;
                    end else if (bus.is_load && c_load_en) begin
                        w_state_nxt = ST_VOID;
                        w_cnt_load  = 1'b1;
                        w_cnt_val   = c_load_val;
                    end
                end
                ST_VOID, ST_FLUSH: begin
                    if (w_cnt_done) begin
                        w_state_nxt = bus.mem_busy ? ST_WAIT_MEM : ST_IDLE;
                    end
                end
                ST_WAIT_MEM: begin
                    if (!bus.mem_busy) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they track r_state exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_out        <= '0;
            r_void_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= decode_outputs(w_state_nxt);
            if (r_out.is_void && (r_void_count != c_stat_max)) begin
                r_void_count <= r_void_count + STAT_W'(1);
            end
        end
    end

    assign bus.is_void    = r_out.is_void;
    assign bus.pc_hold    = r_out.pc_hold;
    assign bus.flush      = r_out.flush;
    assign bus.state_dbg  = r_state;
    assign bus.void_count = r_void_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_hazard_scheduler                                     |
// | Purpose  : Scoreboard bench for two hazard_scheduler configurations|
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_hazard_scheduler;
    import hazard_scheduler_pkg::*;

    localparam logic [1:0] c_i = 2'd0;
    localparam logic [1:0] c_v = 2'd1;
    localparam logic [1:0] c_f = 2'd2;
    localparam logic [1:0] c_w = 2'd3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_scheduler_if #(.STAT_W(16)) ifa ();
    hazard_scheduler_if #(.STAT_W(4))  ifb ();

    hazard_scheduler #(.LOAD_VOID_CYCLES(2), .BRANCH_FLUSH_CYCLES(1), .STAT_W(16)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    hazard_scheduler #(.LOAD_VOID_CYCLES(0), .BRANCH_FLUSH_CYCLES(1), .STAT_W(4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    typedef struct {
        int         sel;
        logic [1:0] st;
        int         vc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_vc[2];
    logic [1:0] prev_st[2];
    int         vc_max[2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock: drive one DUT, push its expectation, pop and compare after the edge.
    task automatic step(input int sel, input logic rst, input logic ld, input logic br,
                        input logic mb, input logic [1:0] exp_st, input string tag);
        exp_t       e;
        logic [1:0] a_st;
        logic       a_v, a_h, a_f;
        logic [31:0] a_vc;
        @(negedge clk);
        rst_n = ~rst;
        ifa.is_load = 1'b0; ifa.is_branch_taken = 1'b0; ifa.mem_busy = 1'b0;
        ifb.is_load = 1'b0; ifb.is_branch_taken = 1'b0; ifb.mem_busy = 1'b0;
        if (sel == 0) begin
            ifa.is_load = ld; ifa.is_branch_taken = br; ifa.mem_busy = mb;
        end else begin
            ifb.is_load = ld; ifb.is_branch_taken = br; ifb.mem_busy = mb;
        end
        if (rst) begin
            exp_vc[0] = 0; exp_vc[1] = 0;
            prev_st[0] = c_i; prev_st[1] = c_i;
        end else begin
            if (prev_st[sel] != c_i && exp_vc[sel] < vc_max[sel]) exp_vc[sel]++;
            prev_st[sel] = exp_st;
        end
        e.sel = sel; e.st = exp_st; e.vc = exp_vc[sel];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (e.sel == 0) begin
            a_st = ifa.state_dbg; a_v = ifa.is_void; a_h = ifa.pc_hold; a_f = ifa.flush;
            a_vc = 32'(ifa.void_count);
        end else begin
            a_st = ifb.state_dbg; a_v = ifb.is_void; a_h = ifb.pc_hold; a_f = ifb.flush;
            a_vc = 32'(ifb.void_count);
        end
        check({tag, ".state"},   32'(a_st), 32'(e.st));
        check({tag, ".is_void"}, 32'(a_v),  32'(e.st != c_i));
        check({tag, ".pc_hold"}, 32'(a_h),  32'(e.st == c_v || e.st == c_w));
        check({tag, ".flush"},   32'(a_f),  32'(e.st == c_f));
        check({tag, ".vcount"},  a_vc,      32'(e.vc));
    endtask

    initial begin
        vc_max[0] = 65535; vc_max[1] = 15;
        exp_vc[0] = 0; exp_vc[1] = 0;
        prev_st[0] = c_i; prev_st[1] = c_i;
        rst_n = 1'b0;
        ifa.is_load = 1'b0; ifa.is_branch_taken = 1'b0; ifa.mem_busy = 1'b0;
        ifb.is_load = 1'b0; ifb.is_branch_taken = 1'b0; ifb.mem_busy = 1'b0;

        step(0, 1, 0, 0, 0, c_i, "rst_a");
        step(1, 1, 0, 0, 0, c_i, "rst_b");

        // Reset in the middle of a load bubble, and a load presented during reset
        step(0, 0, 1, 0, 0, c_v, "t1_load");
        step(0, 0, 0, 0, 0, c_v, "t1_void");
        step(0, 1, 0, 0, 0, c_i, "t1_rst");
        step(0, 1, 1, 0, 0, c_i, "t1_rst_ld");

        // Single load gives two bubbles
        step(0, 0, 1, 0, 0, c_v, "t2_v0");
        step(0, 0, 0, 0, 0, c_v, "t2_v1");
        step(0, 0, 0, 0, 0, c_i, "t2_idle");
        step(0, 0, 0, 0, 0, c_i, "t2_idle2");
        step(0, 1, 0, 0, 0, c_i, "t2_rst");

        // Branch aborts a load bubble
        step(0, 0, 1, 0, 0, c_v, "t3_v");
        step(0, 0, 0, 1, 0, c_f, "t3_flush");
        step(0, 0, 0, 0, 0, c_i, "t3_idle");
        step(0, 0, 0, 0, 0, c_i, "t3_idle2");
        step(0, 1, 0, 0, 0, c_i, "t3_rst");

        // Memory wait follows the load bubble
        step(0, 0, 1, 0, 0, c_v, "t4_v0");
        step(0, 0, 0, 0, 1, c_v, "t4_v1");
        step(0, 0, 0, 0, 1, c_w, "t4_w0");
        step(0, 0, 0, 0, 1, c_w, "t4_w1");
        step(0, 0, 0, 0, 1, c_w, "t4_w2");
        step(0, 0, 0, 0, 0, c_i, "t4_idle");
        step(0, 1, 0, 0, 0, c_i, "t4_rst");

        // Load with mem_busy in IDLE: memory wait first, then the re-presented load
        step(0, 0, 1, 0, 1, c_w, "t5_w0");
        step(0, 0, 1, 0, 1, c_w, "t5_w1");
        step(0, 0, 1, 0, 0, c_i, "t5_idle");
        step(0, 0, 1, 0, 0, c_v, "t5_v0");
        step(0, 0, 0, 0, 0, c_v, "t5_v1");
        step(0, 0, 0, 0, 0, c_i, "t5_done");

        // Branch aborts a memory wait; FLUSH exits to WAIT_MEM while memory is busy
        step(0, 0, 0, 0, 1, c_w, "tx_w");
        step(0, 0, 0, 1, 1, c_f, "tx_brw");
        step(0, 0, 0, 0, 1, c_w, "tx_fw");
        step(0, 0, 0, 0, 0, c_i, "tx_idle");
        // Branch with a load in IDLE discards the load; back-to-back branches re-enter FLUSH
        step(0, 0, 1, 1, 0, c_f, "tx_brld");
        step(0, 0, 0, 0, 0, c_i, "tx_noload");
        step(0, 0, 0, 1, 0, c_f, "tx_br0");
        step(0, 0, 0, 1, 0, c_f, "tx_br1");
        step(0, 0, 0, 0, 0, c_i, "tx_end");

        // Saturation at 15 and disabled load voiding on the narrow instance
        step(1, 1, 0, 0, 0, c_i, "t6_rst");
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0, 1, c_w, $sformatf("t6_w%0d", i));
        end
        step(1, 0, 0, 0, 0, c_i, "t6_idle");
        step(1, 0, 1, 0, 0, c_i, "t6_ld0");
        step(1, 0, 1, 0, 0, c_i, "t6_ld1");
        step(1, 0, 0, 0, 0, c_i, "t6_end");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
